// File: rtl/amiga_m68k_bus_master.sv
// 68000 asynchronous bus initiator: converts a req/ack word-access port into
// S0..S7 bus cycles with _DTACK wait states, _BERR and a watchdog timeout.
module amiga_m68k_bus_master #(
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        _RESET,
  input  logic        req,
  input  logic        we,
  input  logic [22:0] addr,
  input  logic [1:0]  be,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [22:0] A,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  input  logic [15:0] D_IN,
  output logic        _AS,
  output logic        _UDS,
  output logic        _LDS,
  output logic        _PRW,
  input  logic        _DTACK,
  input  logic        _BERR
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {IDLE, S0, S1, S2, S3, S4, S5, S6, S7, WAIT} state_t;

  state_t            state_reg, state_next;
  logic [22:0]       a_reg, a_next;
  logic [15:0]       dout_reg, dout_next;
  logic [15:0]       rdata_reg, rdata_next;
  logic [15:0]       wdata_l_reg, wdata_l_next;
  logic [1:0]        be_l_reg, be_l_next;
  logic              we_l_reg, we_l_next;
  logic              doe_reg, doe_next;
  logic              ack_reg, ack_next;
  logic              err_reg, err_next;
  logic              busy_reg, busy_next;
  logic              as_n_reg, as_n_next;
  logic              uds_n_reg, uds_n_next;
  logic              lds_n_reg, lds_n_next;
  logic              prw_n_reg, prw_n_next;
  logic              err_flag_reg, err_flag_next;
  logic [TW-1:0]     to_cnt_reg, to_cnt_next;
  logic [SYNC_STAGES-1:0] dtack_sync_reg, berr_sync_reg;
  logic              dtack_s, berr_s, timed_out;

  // Both bus responses are asynchronous to CLK; idle level is high.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      dtack_sync_reg <= '1;
      berr_sync_reg  <= '1;
    end else begin
      dtack_sync_reg <= {dtack_sync_reg[SYNC_STAGES-2:0], _DTACK};
      berr_sync_reg  <= {berr_sync_reg[SYNC_STAGES-2:0], _BERR};
    end
  end

  assign dtack_s   = dtack_sync_reg[SYNC_STAGES-1];
  assign berr_s    = berr_sync_reg[SYNC_STAGES-1];
  assign timed_out = (to_cnt_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      dout_reg     <= '0;
      rdata_reg    <= '0;
      wdata_l_reg  <= '0;
      be_l_reg     <= '0;
      we_l_reg     <= 1'b0;
      doe_reg      <= 1'b0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      as_n_reg     <= 1'b1;
      uds_n_reg    <= 1'b1;
      lds_n_reg    <= 1'b1;
      prw_n_reg    <= 1'b1;
      err_flag_reg <= 1'b0;
      to_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      dout_reg     <= dout_next;
      rdata_reg    <= rdata_next;
      wdata_l_reg  <= wdata_l_next;
      be_l_reg     <= be_l_next;
      we_l_reg     <= we_l_next;
      doe_reg      <= doe_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
      busy_reg     <= busy_next;
      as_n_reg     <= as_n_next;
      uds_n_reg    <= uds_n_next;
      lds_n_reg    <= lds_n_next;
      prw_n_reg    <= prw_n_next;
      err_flag_reg <= err_flag_next;
      to_cnt_reg   <= to_cnt_next;
    end
  end

  // Bus outputs are computed for the state being entered, so every pin
  // changes on the same edge as the state register.
  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    dout_next     = dout_reg;
    rdata_next    = rdata_reg;
    wdata_l_next  = wdata_l_reg;
    be_l_next     = be_l_reg;
    we_l_next     = we_l_reg;
    doe_next      = doe_reg;
    ack_next      = 1'b0;
    err_next      = 1'b0;
    as_n_next     = as_n_reg;
    uds_n_next    = uds_n_reg;
    lds_n_next    = lds_n_reg;
    prw_n_next    = prw_n_reg;
    err_flag_next = err_flag_reg;
    to_cnt_next   = to_cnt_reg;
    case (state_reg)
      IDLE: begin
        to_cnt_next   = '0;
        err_flag_next = 1'b0;
        if (req) begin
          if (be != 2'b00) begin
            we_l_next    = we;
            be_l_next    = be;
            wdata_l_next = wdata;
            a_next       = addr;
            prw_n_next   = 1'b1;
            state_next   = S0;
          end else begin
            ack_next = 1'b1;
            err_next = 1'b1;
          end
        end
      end
      S0: state_next = S1;
      S1: begin
        state_next = S2;
        as_n_next  = 1'b0;
        if (we_l_reg) begin
          prw_n_next = 1'b0;
        end else begin
          uds_n_next = ~be_l_reg[1];
          lds_n_next = ~be_l_reg[0];
        end
      end
      S2: begin
        state_next = S3;
        if (we_l_reg) begin
          dout_next = wdata_l_reg;
          doe_next  = 1'b1;
        end
      end
      S3: begin
        state_next = S4;
        if (we_l_reg) begin
          uds_n_next = ~be_l_reg[1];
          lds_n_next = ~be_l_reg[0];
        end
      end
      S4: begin
        to_cnt_next = to_cnt_reg + TW'(1);
        if (!berr_s) begin
          state_next    = S5;
          err_flag_next = 1'b1;
        end else if (!dtack_s) begin
          state_next = S5;
        end else if (timed_out) begin
          state_next    = S5;
          err_flag_next = 1'b1;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        to_cnt_next = to_cnt_reg + TW'(1);
        if (timed_out) begin
          state_next    = S5;
          err_flag_next = 1'b1;
        end else begin
          state_next = S4;
        end
      end
      S5: state_next = S6;
      S6: begin
        state_next = S7;
        as_n_next  = 1'b1;
        uds_n_next = 1'b1;
        lds_n_next = 1'b1;
        ack_next   = 1'b1;
        err_next   = err_flag_reg;
        if (!we_l_reg && !err_flag_reg) rdata_next = D_IN;
      end
      S7: begin
        state_next = IDLE;
        doe_next   = 1'b0;
        prw_n_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_next = (state_next != IDLE);

  assign rdata = rdata_reg;
  assign ack   = ack_reg;
  assign err   = err_reg;
  assign busy  = busy_reg;
  assign A     = a_reg;
  assign D_OUT = dout_reg;
  assign D_OE  = doe_reg;
  assign _AS   = as_n_reg;
  assign _UDS  = uds_n_reg;
  assign _LDS  = lds_n_reg;
  assign _PRW  = prw_n_reg;

endmodule

// File: tb/tb_amiga_m68k_bus_master.sv
// Directed bench for amiga_m68k_bus_master: a table of bus cycles with
// hand-computed timing/data, plus be=00 and mid-cycle reset sequences.
module tb_amiga_m68k_bus_master;

  logic        CLK;
  logic        _RESET;
  logic        req;
  logic        we;
  logic [22:0] addr;
  logic [1:0]  be;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;
  logic [22:0] A;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic [15:0] D_IN;
  logic        _AS;
  logic        _UDS;
  logic        _LDS;
  logic        _PRW;
  logic        _DTACK;
  logic        _BERR;

  int errors = 0;
  int checks = 0;

  amiga_m68k_bus_master #(.TIMEOUT(16), .SYNC_STAGES(2)) dut (
    .CLK(CLK), ._RESET(_RESET), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy), .A(A),
    .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN), ._AS(_AS), ._UDS(_UDS),
    ._LDS(_LDS), ._PRW(_PRW), ._DTACK(_DTACK), ._BERR(_BERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Periods are counted from the edge that samples req: period 1 is the
  // half-state right after it (S0). dtack_at/berr_at: 0 = low before req,
  // 255 = never, n = driven low in the middle of period n.
  typedef struct {
    logic        we;
    logic [22:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] din;
    int          dtack_at;
    int          berr_at;
    int          exp_ack;
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_as_first;
    int          exp_as_last;
    int          exp_strobe_first;
    logic        exp_uds;
    logic        exp_lds;
    int          exp_prw_first;
    int          exp_doe_first;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int   ack_n = 0, as_first = 0, as_last = 0, strobe_first = 0;
    int   prw_first = 0, doe_first = 0;
    logic uds_seen = 0, lds_seen = 0, err_at_ack = 0, doe_at_ack = 0;
    logic [15:0] rdata_at_ack = '0, dout_at_ack = '0;
    logic [22:0] a_at_s0 = '0;
    logic busy_at_s0 = 0;
    @(negedge CLK);
    _DTACK = (v.dtack_at == 0) ? 1'b0 : 1'b1;
    _BERR  = (v.berr_at == 0) ? 1'b0 : 1'b1;
    D_IN   = v.din;
    repeat (3) @(negedge CLK);
    we = v.we; addr = v.addr; be = v.be; wdata = v.wdata; req = 1'b1;
    @(posedge CLK);
    #1 req = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (n == 1) begin a_at_s0 = A; busy_at_s0 = busy; end
      if (!_AS) begin if (as_first == 0) as_first = n; as_last = n; end
      if ((!_UDS || !_LDS) && strobe_first == 0) strobe_first = n;
      if (!_UDS) uds_seen = 1'b1;
      if (!_LDS) lds_seen = 1'b1;
      if (!_PRW && prw_first == 0) prw_first = n;
      if (D_OE && doe_first == 0) doe_first = n;
      if (ack) begin
        ack_n = n; err_at_ack = err; rdata_at_ack = rdata;
        dout_at_ack = D_OUT; doe_at_ack = D_OE;
        break;
      end
      if (n == v.dtack_at) _DTACK = 1'b0;
      if (n == v.berr_at) _BERR = 1'b0;
    end
    chk($sformatf("v%0d ack_period", id), ack_n, v.exp_ack);
    chk($sformatf("v%0d err", id), err_at_ack, v.exp_err);
    chk($sformatf("v%0d rdata", id), rdata_at_ack, v.exp_rdata);
    chk($sformatf("v%0d A", id), a_at_s0, v.addr);
    chk($sformatf("v%0d busy_s0", id), busy_at_s0, 1);
    chk($sformatf("v%0d as_first", id), as_first, v.exp_as_first);
    chk($sformatf("v%0d as_last", id), as_last, v.exp_as_last);
    chk($sformatf("v%0d strobe_first", id), strobe_first, v.exp_strobe_first);
    chk($sformatf("v%0d uds_seen", id), uds_seen, v.exp_uds);
    chk($sformatf("v%0d lds_seen", id), lds_seen, v.exp_lds);
    chk($sformatf("v%0d prw_first", id), prw_first, v.exp_prw_first);
    chk($sformatf("v%0d doe_first", id), doe_first, v.exp_doe_first);
    chk($sformatf("v%0d doe_at_ack", id), doe_at_ack, v.we);
    if (v.we) chk($sformatf("v%0d dout", id), dout_at_ack, v.wdata);
    @(negedge CLK);
    chk($sformatf("v%0d ack_pulse", id), ack, 0);
    chk($sformatf("v%0d busy_idle", id), busy, 0);
    chk($sformatf("v%0d prw_idle", id), _PRW, 1);
    chk($sformatf("v%0d doe_idle", id), D_OE, 0);
    $display("v%0d we=%0d addr=%06h be=%02b ack_period=%0d err=%0d rdata=%04h",
             id, v.we, v.addr, v.be, ack_n, err_at_ack, rdata_at_ack);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack_seen;
    logic as_seen;
    vecs[0] = '{1'b0, 23'h000100, 2'b11, 16'h0000, 16'hBEEF, 0,   255, 8,  1'b0, 16'hBEEF, 3, 7,  3, 1'b1, 1'b1, 0, 0};
    vecs[1] = '{1'b1, 23'h0ABCDE, 2'b11, 16'h1234, 16'h0000, 6,   255, 12, 1'b0, 16'hBEEF, 3, 11, 5, 1'b1, 1'b1, 3, 4};
    vecs[2] = '{1'b0, 23'h000200, 2'b01, 16'h0000, 16'h55AA, 0,   255, 8,  1'b0, 16'h55AA, 3, 7,  3, 1'b0, 1'b1, 0, 0};
    vecs[3] = '{1'b1, 23'h000201, 2'b10, 16'hA500, 16'h0000, 0,   255, 8,  1'b0, 16'h55AA, 3, 7,  5, 1'b1, 1'b0, 3, 4};
    vecs[4] = '{1'b0, 23'h000300, 2'b11, 16'h0000, 16'h1111, 0,   0,   8,  1'b1, 16'h55AA, 3, 7,  3, 1'b1, 1'b1, 0, 0};
    vecs[5] = '{1'b0, 23'h000400, 2'b11, 16'h0000, 16'h2222, 255, 255, 23, 1'b1, 16'h55AA, 3, 22, 3, 1'b1, 1'b1, 0, 0};
    vecs[6] = '{1'b0, 23'h000101, 2'b11, 16'h0000, 16'hCAFE, 0,   255, 8,  1'b0, 16'hCAFE, 3, 7,  3, 1'b1, 1'b1, 0, 0};

    _RESET = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    D_IN = '0; _DTACK = 1'b1; _BERR = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset _AS", _AS, 1);
    chk("reset _UDS", _UDS, 1);
    chk("reset _LDS", _LDS, 1);
    chk("reset _PRW", _PRW, 1);
    chk("reset D_OE", D_OE, 0);
    chk("reset A", A, 0);
    chk("reset D_OUT", D_OUT, 0);
    chk("reset rdata", rdata, 0);
    chk("reset ack/err/busy", {ack, err, busy}, 0);
    _RESET = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // be=00: immediate error acknowledge, no bus activity
    @(negedge CLK);
    be = 2'b00; we = 1'b0; addr = 23'h000500; req = 1'b1;
    @(posedge CLK);
    #1 req = 1'b0;
    @(negedge CLK);
    chk("be00 ack", ack, 1);
    chk("be00 err", err, 1);
    chk("be00 _AS", _AS, 1);
    chk("be00 busy", busy, 0);
    @(negedge CLK);
    chk("be00 ack_pulse", ack, 0);
    $display("be00 request: error ack after one period");

    // Reset asserted during S5 of a write
    _DTACK = 1'b0; _BERR = 1'b1;
    repeat (3) @(negedge CLK);
    we = 1'b1; be = 2'b11; addr = 23'h000600; wdata = 16'h7777; req = 1'b1;
    @(posedge CLK);
    #1 req = 1'b0;
    repeat (6) @(negedge CLK);
    chk("rst_mid pre _AS", _AS, 0);
    chk("rst_mid pre D_OE", D_OE, 1);
    _RESET = 1'b0;
    #1;
    chk("rst_mid strobes", {_AS, _UDS, _LDS, _PRW}, 4'hF);
    chk("rst_mid D_OE", D_OE, 0);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid rdata", rdata, 0);
    @(negedge CLK);
    _RESET = 1'b1;
    ack_seen = 1'b0; as_seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge CLK);
      if (ack) ack_seen = 1'b1;
      if (!_AS) as_seen = 1'b1;
    end
    chk("rst_mid no_ack", ack_seen, 0);
    chk("rst_mid no_as", as_seen, 0);
    $display("reset during S5 of write: bus released");

    run_vec(6, vecs[6]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
